// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - M-stage data memory access sequencer with load extension and store lane steering
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ComputeResultM,
    input  logic [31:0] WriteDataM,
    input  logic        ErrClr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusByteEn,
    input  logic        BusAck,
    input  logic [31:0] BusRData,
    output logic        Busy,
    output logic [31:0] ReadDataM,
    output logic        MemErr,
    output logic [31:0] ErrAddr
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]       eaddr_q, eaddr_d, err_src;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d, err_set;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;

    logic access, mis, timeout;
    logic [1:0] off_i;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    logic [31:0] rext;

    assign access  = MemReadM | MemWriteM;
    assign off_i   = ComputeResultM[1:0];
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (Funct3M)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = off_i[0];
            3'b010:         mis = (off_i != 2'b00);
            default:        mis = 1'b1;
        endcase
    end

    // Lane selection uses the offset latched at request time, not the live address.
    always_comb begin
        rbyte = BusRData[8*off_q +: 8];
        rhalf = off_q[1] ? BusRData[31:16] : BusRData[15:0];
        case (f3_q)
            3'b000:  rext = {{24{rbyte[7]}}, rbyte};
            3'b100:  rext = {24'h0, rbyte};
            3'b001:  rext = {{16{rhalf[15]}}, rhalf};
            3'b101:  rext = {16'h0, rhalf};
            default: rext = BusRData;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access && !mis) state_d = S_REQ;
            S_REQ:   if (BusAck || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = ((state_q == S_IDLE) && access && !mis) || (state_q == S_REQ);
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        err_set = 1'b0;
        err_src = ComputeResultM;
        case (state_q)
            S_IDLE: begin
                if (access && mis) begin
                    err_set = 1'b1;
                end else if (access) begin
                    req_d  = 1'b1;
                    we_d   = MemWriteM;
                    addr_d = {ComputeResultM[31:2], 2'b00};
                    f3_d   = Funct3M;
                    off_d  = off_i;
                    cnt_d  = '0;
                    case (Funct3M[1:0])
                        2'b00: begin
                            be_d    = 4'b0001 << off_i;
                            wdata_d = {4{WriteDataM[7:0]}};
                        end
                        2'b01: begin
                            be_d    = off_i[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{WriteDataM[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = WriteDataM;
                        end
                    endcase
                    if (!MemWriteM) be_d = 4'b1111;
                end
            end
            S_REQ: begin
                if (BusAck) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = rext;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    err_set = 1'b1;
                    err_src = {addr_q[31:2], off_q};
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // A new error overrides a simultaneous clear and records its address.
        err_d   = err_set ? 1'b1 : (ErrClr ? 1'b0 : err_q);
        eaddr_d = (err_set && (!err_q || ErrClr)) ? err_src : eaddr_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            eaddr_q <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            eaddr_q <= eaddr_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign BusReq    = req_q;
    assign BusWe     = we_q;
    assign BusAddr   = addr_q;
    assign BusWData  = wdata_q;
    assign BusByteEn = be_q;
    assign ReadDataM = rdata_q;
    assign MemErr    = err_q;
    assign ErrAddr   = eaddr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed and randomized checks of mem_access_ctrl against a reference model
module tb_mem_access_ctrl;
    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        MemReadM, MemWriteM, ErrClr, BusAck;
    logic [2:0]  Funct3M;
    logic [31:0] ComputeResultM, WriteDataM, BusRData;
    logic        BusReq, BusWe, Busy, MemErr;
    logic [31:0] BusAddr, BusWData, ReadDataM, ErrAddr;
    logic [3:0]  BusByteEn;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .CLK(CLK), .RESETn(RESETn), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ComputeResultM(ComputeResultM), .WriteDataM(WriteDataM),
        .ErrClr(ErrClr), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
        .BusWData(BusWData), .BusByteEn(BusByteEn), .BusAck(BusAck), .BusRData(BusRData),
        .Busy(Busy), .ReadDataM(ReadDataM), .MemErr(MemErr), .ErrAddr(ErrAddr)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_rd, m_eaddr;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic f_mis(input logic [2:0] f3, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        if (f3 == 3'd2) return off != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int unsigned off = addr % 4;
        logic [31:0] b = (rdata >> (8 * off)) % 256;
        logic [31:0] h = (rdata >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // ack_at: REQ cycle index (0-based) on which BusAck is raised; >= T means never.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdata, input logic clr);
        logic        mis = f_mis(f3, addr);
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          nreq;
        if (!wr)            begin ebe = 4'hF;                    ewd = 32'h0; end
        else if (f3 == 3'd0) begin ebe = 4'(1 << (addr % 4));     ewd = (wd % 256) * 32'h01010101; end
        else if (f3 == 3'd1) begin ebe = (addr % 4 >= 2) ? 4'hC : 4'h3; ewd = (wd % 65536) * 32'h00010001; end
        else                begin ebe = 4'hF;                    ewd = wd; end
        @(negedge CLK);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ComputeResultM = addr;
        WriteDataM = wd; BusRData = rdata; ErrClr = clr;
        #1;
        if (mis) begin
            chk("mis_busy", {31'h0, Busy}, 32'h0);
            @(negedge CLK);
            ErrClr = 1'b0;
            if (!m_err || clr) m_eaddr = addr;
            m_err = 1'b1;
            chk("mis_busreq", {31'h0, BusReq}, 32'h0);
            chk("mis_memerr", {31'h0, MemErr}, {31'h0, m_err});
            chk("mis_erraddr", ErrAddr, m_eaddr);
            chk("mis_rdata", ReadDataM, m_rd);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            return;
        end
        chk("idle_busy", {31'h0, Busy}, 32'h1);
        nreq = (ack_at < T) ? ack_at + 1 : T;
        for (int i = 0; i < nreq; i++) begin
            @(negedge CLK);
            ErrClr = 1'b0;
            chk("req_busreq", {31'h0, BusReq}, 32'h1);
            chk("req_busy", {31'h0, Busy}, 32'h1);
            chk("req_we", {31'h0, BusWe}, {31'h0, wr});
            chk("req_addr", BusAddr, addr - (addr % 4));
            chk("req_be", {28'h0, BusByteEn}, {28'h0, ebe});
            if (wr) chk("req_wdata", BusWData, ewd);
            BusAck = (i == ack_at);
        end
        @(negedge CLK);
        BusAck = 1'b0;
        if (ack_at < T) begin
            if (!wr) m_rd = f_load(f3, addr, rdata);
        end else begin
            if (!wr) m_rd = 32'h0;
            if (!m_err) m_eaddr = addr;
            m_err = 1'b1;
        end
        chk("done_busreq", {31'h0, BusReq}, 32'h0);
        chk("done_busy", {31'h0, Busy}, 32'h0);
        chk("done_rdata", ReadDataM, m_rd);
        chk("done_memerr", {31'h0, MemErr}, {31'h0, m_err});
        chk("done_erraddr", ErrAddr, m_eaddr);
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge CLK);
        ErrClr = 1'b1;
        @(negedge CLK);
        ErrClr = 1'b0;
        m_err = 1'b0;
        chk("clr_memerr", {31'h0, MemErr}, 32'h0);
        chk("clr_erraddr", ErrAddr, m_eaddr);
    endtask

    initial begin
        RESETn = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ErrClr = 1'b0; BusAck = 1'b0;
        Funct3M = 3'd0; ComputeResultM = 32'h0; WriteDataM = 32'h0; BusRData = 32'h0;
        m_rd = 32'h0; m_err = 1'b0; m_eaddr = 32'h0;
        @(negedge CLK); @(negedge CLK);
        chk("rst_busreq", {31'h0, BusReq}, 32'h0);
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        chk("rst_busaddr", BusAddr, 32'h0);
        chk("rst_wdata", BusWData, 32'h0);
        chk("rst_be", {28'h0, BusByteEn}, 32'h0);
        chk("rst_rdata", ReadDataM, 32'h0);
        chk("rst_memerr", {31'h0, MemErr}, 32'h0);
        chk("rst_erraddr", ErrAddr, 32'h0);
        RESETn = 1'b1;

        do_access(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
        chk("lw_value", ReadDataM, 32'hDEADBEEF);
        do_access(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80AABBCC, 0);
        chk("lb_value", ReadDataM, 32'hFFFFFF80);
        do_access(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80AABBCC, 0);
        chk("lbu_value", ReadDataM, 32'h00000080);
        do_access(1, 0, 3'd5, 32'h102, 32'h0, 0, 32'h12345678, 0);
        chk("lhu_value", ReadDataM, 32'h00001234);
        do_access(0, 1, 3'd0, 32'h201, 32'h000000A5, 2, 32'h0, 0);
        chk("sb_wdata", BusWData, 32'hA5A5A5A5);
        chk("sb_be", {28'h0, BusByteEn}, 32'h2);
        do_access(1, 1, 3'd1, 32'h20E, 32'h0000BEEF, 0, 32'h0, 0);
        chk("both_is_store", {31'h0, BusWe}, 32'h1);
        do_access(1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0, 0);
        do_access(1, 0, 3'd1, 32'h305, 32'h0, 0, 32'h0, 0);
        chk("first_erraddr", ErrAddr, 32'h102);
        clear_err();
        do_access(1, 0, 3'd3, 32'h400, 32'h0, 0, 32'h0, 0);
        clear_err();
        do_access(1, 0, 3'd6, 32'h404, 32'h0, 0, 32'h0, 1);
        chk("err_beats_clr", {31'h0, MemErr}, 32'h1);
        clear_err();
        do_access(1, 0, 3'd2, 32'h500, 32'h0, 99, 32'h11111111, 0);
        chk("timeout_rdata", ReadDataM, 32'h0);
        chk("timeout_erraddr", ErrAddr, 32'h500);
        clear_err();

        // Reset in the middle of a request
        @(negedge CLK);
        MemReadM = 1'b1; Funct3M = 3'd2; ComputeResultM = 32'h600;
        @(negedge CLK);
        chk("pre_rst_busreq", {31'h0, BusReq}, 32'h1);
        RESETn = 1'b0; MemReadM = 1'b0;
        #1;
        chk("rst_mid_busreq", {31'h0, BusReq}, 32'h0);
        chk("rst_mid_busy", {31'h0, Busy}, 32'h0);
        @(negedge CLK);
        RESETn = 1'b1; BusAck = 1'b1; BusRData = 32'hCAFEF00D;
        m_rd = 32'h0; m_err = 1'b0; m_eaddr = 32'h0;
        @(negedge CLK);
        BusAck = 1'b0;
        chk("post_rst_busreq", {31'h0, BusReq}, 32'h0);
        chk("post_rst_busy", {31'h0, Busy}, 32'h0);
        chk("post_rst_rdata", ReadDataM, 32'h0);
        do_access(1, 0, 3'd2, 32'h700, 32'h0, 0, 32'h76543210, 0);

        for (int n = 0; n < 150; n++) begin
            int          kind = int'($urandom_range(0, 3));
            logic        rd = (kind != 2);
            logic        wr = (kind >= 2);
            logic [2:0]  f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            do_access(rd, wr, f3, addr, $urandom, int'($urandom_range(0, 5)), $urandom, 0);
            if ($urandom_range(0, 4) == 0) clear_err();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the Memory stage over a req/ack bus. Drives Busy to freeze all pipeline registers until the access completes. Also performs load sign/zero extension and store byte-lane steering from Funct3M. It sits between the EX/MEM register outputs and the data bus, and flags misaligned or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, REQ cycles without BusAck before the access is aborted (must be ≥1)
CNT_W, 8, timeout counter width (2^CNT_W > TIMEOUT_CYCLES)

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
MemReadM  in  1  load in M stage (MemtoRegM)
MemWriteM  in  1  store in M stage
Funct3M  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
ComputeResultM  in  32  byte address
WriteDataM  in  32  store data (low bits)
ErrClr  in  1  clears sticky MemErr
BusReq  out  1  bus request, registered
BusWe  out  1  1 = write, registered
BusAddr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
BusWData  out  32  lane-replicated store data, registered
BusByteEn  out  4  byte enables, registered
BusAck  in  1  completion; sampled only while BusReq=1
BusRData  in  32  read word, valid with BusAck
Busy  out  1  pipeline freeze, combinational
ReadDataM  out  32  extended load result
MemErr  out  1  sticky error flag
ErrAddr  out  32  address of first error since clear

Behaviour:
- Reset (async, RESETn=0): state IDLE; BusReq, BusWe, BusAddr, BusWData, BusByteEn = 0; ReadDataM = 0; MemErr = 0; ErrAddr = 0; counter = 0. Takes effect immediately; an in-flight access is dropped without waiting for ack.
- access = MemReadM|MemWriteM.
- mis = (LH/LHU/SH & addr[0]) | (LW/SW & addr[1:0]!=0). Funct3 values 011, 110, 111 are treated as mis.
- States IDLE, REQ, DONE.
- IDLE:
  - access & !mis: load bus outputs, BusReq←1, go to REQ.
  - access & mis: no request; MemErr←1 and ErrAddr←addr if MemErr was 0; stay IDLE. A misaligned load returns ReadDataM unchanged and the store is dropped.
- REQ:
  - Bus outputs held stable.
  - BusAck=1: BusReq←0, ReadDataM←extend(BusRData) if load, go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: BusReq←0, MemErr/ErrAddr set as above, ReadDataM←0 for loads, go to DONE.
  - Else counter++. Counter clears on entering REQ.
- DONE: one cycle; M-stage inputs are ignored here because they still hold the completed instruction. Always go to IDLE.
- Busy = (IDLE & access & !mis) | REQ. Busy is 0 in DONE, so the pipeline advances at the end of DONE.
- Latency: ack on the first REQ cycle gives Busy high for 2 cycles; data is on ReadDataM during DONE and holds until the next load completion.
- Store lanes:
  - SB: BusByteEn = 1<<addr[1:0], BusWData = {4{wd[7:0]}}.
  - SH: BusByteEn = addr[1] ? 1100 : 0011, BusWData = {2{wd[15:0]}}.
  - SW: BusByteEn = 1111, BusWData = wd.
- Loads: BusByteEn = 1111, BusWe = 0. The selected byte or halfword (by addr[1:0]) is sign-extended (LB/LH) or zero-extended (LBU/LHU).
- MemErr stays set until ErrClr=1. If an error and ErrClr occur in the same cycle, the error wins (MemErr stays 1, ErrAddr updated).
- BusAck outside REQ is ignored.
- If MemReadM and MemWriteM are both 1, the access is treated as a store.

Test Plan:
- LW at 0x100, BusAck on the first REQ cycle, BusRData=0xDEADBEEF -> BusReq high 1 cycle; Busy high 2 cycles; ReadDataM=0xDEADBEEF in DONE; BusAddr=0x100, BusByteEn=1111.
- LB at 0x103 with BusRData=0x80AABBCC -> ReadDataM=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 with BusRData=0x1234_5678 -> 0x00001234.
- SB at 0x201 with WriteDataM=0x000000A5, BusAck after 3 cycles -> BusWe=1, BusByteEn=0010, BusWData=0xA5A5A5A5; address and data stable for all 3 REQ cycles; Busy high 4 cycles.
- LW at 0x102 -> no BusReq; Busy stays 0; MemErr=1, ErrAddr=0x102. A second misaligned access at 0x305 leaves ErrAddr at 0x102. ErrClr -> MemErr=0.
- TIMEOUT_CYCLES=4, load with no ack -> BusReq high exactly 4 cycles; then DONE with MemErr=1, ReadDataM=0, Busy low.
- RESETn pulled low during REQ -> BusReq and Busy drop immediately. After release the controller is in IDLE, and an ack arriving after reset is ignored.
